core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Parametrised fetch/execute sequencer for the single-cycle RISC-V core.
- Replaces the hardwired fixed-period pulse counter with a latency-aware state machine. Fetch waits exactly IMEM_LATENCY cycles; loads additionally wait DMEM_LATENCY cycles.
- Adds run/halt/single-step control, a PC breakpoint, halt-cause reporting, and cycle/retired-instruction counters.
- Sits between instruction BRAM, register file, execute and data BRAM. Owns the PC and the commit strobe.

Parameters:
- XLEN, 32, PC/address width
- RESET_PC, 0, PC value loaded on reset
- IMEM_LATENCY, 2, instruction BRAM read latency in cycles (>=1)
- DMEM_LATENCY, 2, data BRAM read latency in cycles (>=1)
- CNT_WIDTH, 32, width of the performance counters

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- run_in  input  1  level; 1 = free-run
- step_in  input  1  one-cycle pulse; execute one instruction while halted
- halt_req_in  input  1  level; request halt at the next commit
- bp_en_in  input  1  breakpoint enable
- bp_addr_in  input  XLEN  breakpoint PC
- inst_in  input  32  instruction BRAM output
- is_load_in  input  1  decoded iType == LOAD
- next_pc_in  input  XLEN  next PC from execute
- pc_out  output  XLEN  current PC (drives instruction BRAM address)
- commit_out  output  1  one-cycle strobe; gates register-file write, store write and PC update
- state_out  output  3  encoded FSM state
- halted_out  output  1  high in HALT
- halt_cause_out  output  2  0 none, 1 zero instruction, 2 breakpoint, 3 external/step
- cycle_count_out  output  CNT_WIDTH  non-halted cycles
- retired_count_out  output  CNT_WIDTH  committed instructions

Behaviour:
- Reset (async, rst_n_in=0) forces, immediately and for the duration:
  - state=HALT, pc_out=RESET_PC, commit_out=0, halted_out=1, halt_cause_out=0
  - both counters=0, internal wait counter=0, bp_skip=0
- Reset mid-instruction abandons the instruction with no commit.
- States: HALT=0, FETCH=1, EXEC=2, MEM=3, COMMIT=4. State is registered; commit_out=1 only in COMMIT.
- HALT:
  - run_in=1 -> FETCH.
  - Else step_in=1 -> FETCH with step flag set.
  - run_in takes priority when both are asserted.
  - Entering FETCH from HALT sets bp_skip=1 so a breakpoint halt can be resumed.
- FETCH:
  - Wait counter counts IMEM_LATENCY cycles from entry.
  - On the last cycle, if bp_en_in && pc_out==bp_addr_in && !bp_skip -> HALT, cause=2. Otherwise -> EXEC.
  - bp_skip clears on leaving FETCH.
- EXEC:
  - inst_in==0 -> HALT, cause=1, no commit. Resuming re-fetches the same PC and halts again until reset.
  - Else is_load_in -> MEM; else -> COMMIT.
- MEM: wait DMEM_LATENCY cycles -> COMMIT.
- COMMIT:
  - commit_out=1; pc_out<=next_pc_in; retired_count+1.
  - Next state: if step flag, or run_in==0, or halt_req_in -> HALT, cause=3, step flag cleared. Else -> FETCH.
- Halt requests never abort an in-flight instruction; they take effect only at COMMIT.
- Latency per instruction:
  - non-load: IMEM_LATENCY+2 cycles (default 4)
  - load: IMEM_LATENCY+DMEM_LATENCY+2 cycles (default 6)
- cycle_count increments every cycle state!=HALT.
- Both counters saturate at all-ones; no wrap.
- pc_out is not masked or aligned; the caller indexes the BRAM with pc_out[..:2]. PC arithmetic wraps modulo 2^XLEN per next_pc_in.
- halt_cause_out holds its value until the next HALT entry. It is cleared only by reset.

Test Plan:
- Reset, run_in=1, inst_in=0x00500093 (addi x1,x0,5), next_pc_in=pc+4 -> commit_out pulses every 4 cycles; pc_out 0,4,8,...; retired_count_out=3 after 12 cycles post-FETCH entry.
- Load instruction mid-stream (is_load_in=1) -> 6-cycle gap between commits; exactly one commit_out pulse.
- bp_en_in=1, bp_addr_in=0x8, free-run -> HALT with cause=2, pc_out=0x8, retired=2. Then run_in 0->1 -> instruction at 0x8 commits with no re-halt at 0x8.
- Halted, run_in=0, two step_in pulses 20 cycles apart -> exactly two commits, pc advances by 8, cause=3, cycle_count_out=8.
- inst_in=0 at pc 0xC -> HALT cause=1 after EXEC, no commit, retired=3. halt_req_in pulsed during FETCH of a normal instruction -> that instruction still commits, then HALT cause=3.
- rst_n_in low during MEM -> commit_out=0 immediately; pc_out=RESET_PC; counters=0; state_out=0.

Source files
------------

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - latency-aware fetch/execute sequencer with run/halt/step control
module core_sequencer #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_PC     = '0,
  parameter int                IMEM_LATENCY = 2,
  parameter int                DMEM_LATENCY = 2,
  parameter int                CNT_WIDTH    = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 run_in,
  input  logic                 step_in,
  input  logic                 halt_req_in,
  input  logic                 bp_en_in,
  input  logic [XLEN-1:0]      bp_addr_in,
  input  logic [31:0]          inst_in,
  input  logic                 is_load_in,
  input  logic [XLEN-1:0]      next_pc_in,
  output logic [XLEN-1:0]      pc_out,
  output logic                 commit_out,
  output logic [2:0]           state_out,
  output logic                 halted_out,
  output logic [1:0]           halt_cause_out,
  output logic [CNT_WIDTH-1:0] cycle_count_out,
  output logic [CNT_WIDTH-1:0] retired_count_out
);

  localparam int MAX_LAT = (IMEM_LATENCY > DMEM_LATENCY) ? IMEM_LATENCY : DMEM_LATENCY;
  localparam int WAIT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [WAIT_W-1:0] IMEM_LAST = WAIT_W'(IMEM_LATENCY - 1);
  localparam logic [WAIT_W-1:0] DMEM_LAST = WAIT_W'(DMEM_LATENCY - 1);

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_ZERO = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_EXT  = 2'd3;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [1:0]            cause_q, cause_d;
  logic                  bp_skip_q, bp_skip_d;
  logic                  step_q, step_d;
  logic                  halt_pend_q, halt_pend_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;

  // Registered FSM state, PC, flags and counters; reset lands in HALT at RESET_PC
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_HALT;
      wait_q      <= '0;
      pc_q        <= RESET_PC;
      cause_q     <= CAUSE_NONE;
      bp_skip_q   <= 1'b0;
      step_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      cycle_q     <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pc_q        <= pc_d;
      cause_q     <= cause_d;
      bp_skip_q   <= bp_skip_d;
      step_q      <= step_d;
      halt_pend_q <= halt_pend_d;
      cycle_q     <= cycle_d;
      retired_q   <= retired_d;
    end
  end

  // Next-state logic: latency waits, breakpoint/zero-instruction/commit halts, counters
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    bp_skip_d   = bp_skip_q;
    step_d      = step_q;
    halt_pend_d = halt_pend_q;

    // A short halt_req pulse mid-instruction is remembered until the next commit.
    if ((state_q != ST_HALT) && halt_req_in) begin
      halt_pend_d = 1'b1;
    end

    case (state_q)
      ST_HALT: begin
        if (run_in || step_in) begin
          state_d   = ST_FETCH;
          wait_d    = '0;
          bp_skip_d = 1'b1;
          step_d    = !run_in;
        end
      end
      ST_FETCH: begin
        if (wait_q == IMEM_LAST) begin
          wait_d    = '0;
          bp_skip_d = 1'b0;
          if (bp_en_in && (pc_q == bp_addr_in) && !bp_skip_q) begin
            state_d = ST_HALT;
            cause_d = CAUSE_BP;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_EXEC: begin
        if (inst_in == 32'd0) begin
          state_d = ST_HALT;
          cause_d = CAUSE_ZERO;
        end else if (is_load_in) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_MEM: begin
        if (wait_q == DMEM_LAST) begin
          wait_d  = '0;
          state_d = ST_COMMIT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        pc_d   = next_pc_in;
        wait_d = '0;
        if (step_q || !run_in || halt_req_in || halt_pend_q) begin
          state_d = ST_HALT;
          cause_d = CAUSE_EXT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_HALT;
        wait_d  = '0;
      end
    endcase

    // Any halt consumes a pending step or halt request.
    if (state_d == ST_HALT) begin
      step_d      = 1'b0;
      halt_pend_d = 1'b0;
    end

    cycle_d = cycle_q;
    if ((state_q != ST_HALT) && (cycle_q != '1)) begin
      cycle_d = cycle_q + 1'b1;
    end

    retired_d = retired_q;
    if ((state_q == ST_COMMIT) && (retired_q != '1)) begin
      retired_d = retired_q + 1'b1;
    end
  end

  assign pc_out            = pc_q;
  assign commit_out        = (state_q == ST_COMMIT);
  assign state_out         = state_q;
  assign halted_out        = (state_q == ST_HALT);
  assign halt_cause_out    = cause_q;
  assign cycle_count_out   = cycle_q;
  assign retired_count_out = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        run_in;
  logic        step_in;
  logic        halt_req_in;
  logic        bp_en_in;
  logic [31:0] bp_addr_in;
  logic [31:0] inst_in;
  logic        is_load_in;
  logic [31:0] next_pc_in;
  logic [31:0] pc_out;
  logic        commit_out;
  logic [2:0]  state_out;
  logic        halted_out;
  logic [1:0]  halt_cause_out;
  logic [31:0] cycle_count_out;
  logic [31:0] retired_count_out;

  logic        zero_en;
  logic [31:0] zero_pc;
  logic        load_en;
  logic [31:0] load_pc;

  int tests = 0;
  int fails = 0;

  core_sequencer dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .run_in            (run_in),
    .step_in           (step_in),
    .halt_req_in       (halt_req_in),
    .bp_en_in          (bp_en_in),
    .bp_addr_in        (bp_addr_in),
    .inst_in           (inst_in),
    .is_load_in        (is_load_in),
    .next_pc_in        (next_pc_in),
    .pc_out            (pc_out),
    .commit_out        (commit_out),
    .state_out         (state_out),
    .halted_out        (halted_out),
    .halt_cause_out    (halt_cause_out),
    .cycle_count_out   (cycle_count_out),
    .retired_count_out (retired_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Instruction memory / execute stand-in keyed on the current PC
  always_comb begin
    inst_in    = 32'h0050_0093;
    if (zero_en && (pc_out == zero_pc)) inst_in = 32'd0;
    is_load_in = load_en && (pc_out == load_pc);
    next_pc_in = pc_out + 32'd4;
  end

  task automatic nclk;
    @(negedge clk_in);
  endtask

  task automatic do_reset;
    rst_n_in    = 1'b0;
    run_in      = 1'b0;
    step_in     = 1'b0;
    halt_req_in = 1'b0;
    bp_en_in    = 1'b0;
    bp_addr_in  = 32'd0;
    zero_en     = 1'b0;
    zero_pc     = 32'd0;
    load_en     = 1'b0;
    load_pc     = 32'd0;
    nclk;
    nclk;
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    rst_n_in = 1'b0;
    run_in   = 1'b1;
    nclk;
    nclk;
    if (state_out !== 3'd0) begin $display("FAIL reset_state: got %0d expected 0", state_out); fails++; end
    tests++;
    if (pc_out !== 32'd0) begin $display("FAIL reset_pc: got %0h expected 0", pc_out); fails++; end
    tests++;
    if (commit_out !== 1'b0 || halted_out !== 1'b1) begin
      $display("FAIL reset_flags: got commit=%0b halted=%0b expected commit=0 halted=1", commit_out, halted_out); fails++;
    end
    tests++;
    if (halt_cause_out !== 2'd0 || cycle_count_out !== 32'd0 || retired_count_out !== 32'd0) begin
      $display("FAIL reset_counters: got cause=%0d cyc=%0d ret=%0d expected 0 0 0", halt_cause_out, cycle_count_out, retired_count_out); fails++;
    end
    tests++;
    run_in = 1'b0;
  endtask

  task automatic test_free_run;
    logic        exp_c;
    logic [31:0] exp_pc;
    do_reset;
    run_in = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      nclk;
      exp_c  = (k % 4 == 0);
      exp_pc = 32'(((k - 1) / 4) * 4);
      if (commit_out !== exp_c) begin $display("FAIL free_run_commit k=%0d: got %0b expected %0b", k, commit_out, exp_c); fails++; end
      tests++;
      if (pc_out !== exp_pc) begin $display("FAIL free_run_pc k=%0d: got %0h expected %0h", k, pc_out, exp_pc); fails++; end
      tests++;
      if (k == 1 && state_out !== 3'd1) begin $display("FAIL free_run_fetch: got %0d expected 1", state_out); fails++; end
      if (k == 1) tests++;
      if (k == 3 && state_out !== 3'd2) begin $display("FAIL free_run_exec: got %0d expected 2", state_out); fails++; end
      if (k == 3) tests++;
      if (k == 4 && state_out !== 3'd4) begin $display("FAIL free_run_commit_state: got %0d expected 4", state_out); fails++; end
      if (k == 4) tests++;
    end
    if (retired_count_out !== 32'd3) begin $display("FAIL free_run_retired: got %0d expected 3", retired_count_out); fails++; end
    tests++;
    if (cycle_count_out !== 32'd12) begin $display("FAIL free_run_cycles: got %0d expected 12", cycle_count_out); fails++; end
    tests++;
    run_in = 1'b0;
  endtask

  task automatic test_load;
    logic exp_c;
    int   commits;
    commits = 0;
    do_reset;
    load_en = 1'b1;
    load_pc = 32'h4;
    run_in  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      nclk;
      exp_c = (k == 4) || (k == 10) || (k == 14);
      if (commit_out) commits++;
      if (commit_out !== exp_c) begin $display("FAIL load_commit k=%0d: got %0b expected %0b", k, commit_out, exp_c); fails++; end
      tests++;
      if (k == 8 && state_out !== 3'd3) begin $display("FAIL load_mem_state: got %0d expected 3", state_out); fails++; end
      if (k == 8) tests++;
    end
    if (commits != 3) begin $display("FAIL load_commit_count: got %0d expected 3", commits); fails++; end
    tests++;
    run_in = 1'b0;
  endtask

  task automatic test_breakpoint;
    logic exp_c;
    do_reset;
    bp_en_in   = 1'b1;
    bp_addr_in = 32'h8;
    run_in     = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      nclk;
      exp_c = (k == 4) || (k == 8);
      if (commit_out !== exp_c) begin $display("FAIL bp_commit k=%0d: got %0b expected %0b", k, commit_out, exp_c); fails++; end
      tests++;
    end
    if (halted_out !== 1'b1 || halt_cause_out !== 2'd2) begin
      $display("FAIL bp_halt: got halted=%0b cause=%0d expected halted=1 cause=2", halted_out, halt_cause_out); fails++;
    end
    tests++;
    if (pc_out !== 32'h8 || retired_count_out !== 32'd2) begin
      $display("FAIL bp_pc_retired: got pc=%0h ret=%0d expected pc=8 ret=2", pc_out, retired_count_out); fails++;
    end
    tests++;
    run_in = 1'b0;
    repeat (3) nclk;
    if (halted_out !== 1'b1 || pc_out !== 32'h8) begin
      $display("FAIL bp_hold: got halted=%0b pc=%0h expected halted=1 pc=8", halted_out, pc_out); fails++;
    end
    tests++;
    run_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      nclk;
      exp_c = (k == 4);
      if (commit_out !== exp_c) begin $display("FAIL bp_resume_commit k=%0d: got %0b expected %0b", k, commit_out, exp_c); fails++; end
      tests++;
    end
    if (pc_out !== 32'hC || halted_out !== 1'b0) begin
      $display("FAIL bp_resume_pc: got pc=%0h halted=%0b expected pc=c halted=0", pc_out, halted_out); fails++;
    end
    tests++;
    run_in   = 1'b0;
    bp_en_in = 1'b0;
  endtask

  task automatic test_step;
    int commits;
    commits = 0;
    do_reset;
    repeat (3) nclk;
    if (halted_out !== 1'b1 || cycle_count_out !== 32'd0) begin
      $display("FAIL step_idle: got halted=%0b cyc=%0d expected halted=1 cyc=0", halted_out, cycle_count_out); fails++;
    end
    tests++;
    for (int s = 0; s < 2; s++) begin
      step_in = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        nclk;
        if (k == 1) step_in = 1'b0;
        if (commit_out) commits++;
      end
      if (pc_out !== 32'((s + 1) * 4) || halted_out !== 1'b1) begin
        $display("FAIL step_pc s=%0d: got pc=%0h halted=%0b expected pc=%0h halted=1", s, pc_out, halted_out, (s + 1) * 4); fails++;
      end
      tests++;
    end
    if (commits != 2) begin $display("FAIL step_commits: got %0d expected 2", commits); fails++; end
    tests++;
    if (halt_cause_out !== 2'd3) begin $display("FAIL step_cause: got %0d expected 3", halt_cause_out); fails++; end
    tests++;
    if (cycle_count_out !== 32'd8 || retired_count_out !== 32'd2) begin
      $display("FAIL step_counters: got cyc=%0d ret=%0d expected cyc=8 ret=2", cycle_count_out, retired_count_out); fails++;
    end
    tests++;
  endtask

  task automatic test_zero_inst;
    int commits;
    commits = 0;
    do_reset;
    zero_en = 1'b1;
    zero_pc = 32'hC;
    run_in  = 1'b1;
    repeat (16) nclk;
    if (halted_out !== 1'b1 || halt_cause_out !== 2'd1) begin
      $display("FAIL zero_halt: got halted=%0b cause=%0d expected halted=1 cause=1", halted_out, halt_cause_out); fails++;
    end
    tests++;
    if (pc_out !== 32'hC || retired_count_out !== 32'd3) begin
      $display("FAIL zero_pc_retired: got pc=%0h ret=%0d expected pc=c ret=3", pc_out, retired_count_out); fails++;
    end
    tests++;
    for (int k = 1; k <= 10; k++) begin
      nclk;
      if (commit_out) commits++;
    end
    if (commits != 0 || pc_out !== 32'hC || retired_count_out !== 32'd3) begin
      $display("FAIL zero_rehalt: got commits=%0d pc=%0h ret=%0d expected 0 c 3", commits, pc_out, retired_count_out); fails++;
    end
    tests++;
    run_in = 1'b0;
  endtask

  task automatic test_halt_req;
    logic exp_c;
    do_reset;
    run_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      nclk;
      exp_c = (k == 4) || (k == 8);
      if (k <= 8) begin
        if (commit_out !== exp_c) begin $display("FAIL halt_req_commit k=%0d: got %0b expected %0b", k, commit_out, exp_c); fails++; end
        tests++;
      end
      if (k == 5) halt_req_in = 1'b1;
      if (k == 6) halt_req_in = 1'b0;
    end
    if (halted_out !== 1'b1 || halt_cause_out !== 2'd3) begin
      $display("FAIL halt_req_halt: got halted=%0b cause=%0d expected halted=1 cause=3", halted_out, halt_cause_out); fails++;
    end
    tests++;
    if (pc_out !== 32'h8 || retired_count_out !== 32'd2) begin
      $display("FAIL halt_req_pc: got pc=%0h ret=%0d expected pc=8 ret=2", pc_out, retired_count_out); fails++;
    end
    tests++;
    run_in = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    load_en = 1'b1;
    load_pc = 32'h4;
    run_in  = 1'b1;
    repeat (8) nclk;
    if (state_out !== 3'd3 || pc_out !== 32'h4) begin
      $display("FAIL mid_pre: got state=%0d pc=%0h expected state=3 pc=4", state_out, pc_out); fails++;
    end
    tests++;
    rst_n_in = 1'b0;
    #1;
    if (commit_out !== 1'b0 || state_out !== 3'd0 || pc_out !== 32'd0) begin
      $display("FAIL mid_reset: got commit=%0b state=%0d pc=%0h expected 0 0 0", commit_out, state_out, pc_out); fails++;
    end
    tests++;
    if (cycle_count_out !== 32'd0 || retired_count_out !== 32'd0) begin
      $display("FAIL mid_reset_counters: got cyc=%0d ret=%0d expected 0 0", cycle_count_out, retired_count_out); fails++;
    end
    tests++;
    nclk;
    rst_n_in = 1'b1;
    run_in   = 1'b0;
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_load;
    test_breakpoint;
    test_step;
    test_zero_inst;
    test_halt_req;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
